// File: rtl/imul_copro.sv
// Iterative integer multiply/divide coprocessor on a narrow register bus; W cycles per op, cmd_end held until end_ack.
// No backpressure: host polls busy/STATUS or waits for cmd_end; define IMUL_SIGNED_EN to enable signed opcodes 10/11.
module imul_copro #(
    parameter int W  = 32,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [BW-1:0] databus_in,
    output logic [BW-1:0] databus_out,
    input  logic [3:0]    addr,
    input  logic          cs,
    input  logic          rd,
    input  logic          wr,
    input  logic          end_ack,
    output logic          cmd_end,
    output logic          busy
);

    localparam int NCH = W / BW;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_opnd;
    logic [CW-1:0]  r_cnt;
    logic           r_is_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_ovf_pend;
    logic [2*W-1:0] r_res;
    logic [PW-1:0]  r_ptr_lo;
    logic [PW-1:0]  r_ptr_hi;
    logic           r_cmd_end;
    logic           r_dbz;
    logic           r_ovf;
    logic           r_err_busy;
    logic           r_bad_op;

    logic           w_wr;
    logic           w_rd;
    logic           w_cmd_wr;
    logic           w_sgn;
    logic           w_op_ok;
    logic           w_accept;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_abs;
    logic [W-1:0]   w_b_abs;
    logic           w_ovf_det;
    logic [W-1:0]   w_a_nxt;
    logic [W-1:0]   w_b_nxt;
    logic [W:0]     w_add;
    logic [W:0]     w_rsh;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_acc_nx;
    logic [W-1:0]   w_lo_nx;
    logic [2*W-1:0] w_mag;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic           w_dbz;
    logic [2*W-1:0] w_final;
    logic           w_last;
    logic [5:0]     w_status;

    assign w_wr     = cs & wr;
    assign w_rd     = cs & rd;
    assign w_cmd_wr = w_wr & (addr == 4'd2);

`ifdef IMUL_SIGNED_EN
    assign w_sgn   = databus_in[1];
    assign w_op_ok = 1'b1;
`else
    assign w_sgn   = 1'b0;
    assign w_op_ok = ~databus_in[1];
`endif

    assign w_accept  = w_cmd_wr & (r_state != S_RUN) & w_op_ok;
    assign w_a_neg   = w_sgn & r_a[W-1];
    assign w_b_neg   = w_sgn & r_b[W-1];
    assign w_a_abs   = w_a_neg ? -r_a : r_a;
    assign w_b_abs   = w_b_neg ? -r_b : r_b;
    assign w_ovf_det = w_sgn & databus_in[0] & (r_a == {1'b1, {(W-1){1'b0}}}) & (&r_b);

    // Operand ports fill LS chunk first: each write pushes the new chunk in at the top.
    generate
        if (W > BW) begin : g_shift
            assign w_a_nxt = {databus_in, r_a[W-1:BW]};
            assign w_b_nxt = {databus_in, r_b[W-1:BW]};
        end else begin : g_load
            assign w_a_nxt = databus_in;
            assign w_b_nxt = databus_in;
        end
    endgenerate

    assign w_add  = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_opnd : {W{1'b0}})};
    assign w_rsh  = {r_acc, r_lo[W-1]};
    assign w_diff = w_rsh - {1'b0, r_opnd};

    always_comb begin
        w_acc_nx = w_add[W:1];
        w_lo_nx  = {w_add[0], r_lo[W-1:1]};
        if (r_is_div) begin
            if (!w_diff[W]) begin
                w_acc_nx = w_diff[W-1:0];
                w_lo_nx  = {r_lo[W-2:0], 1'b1};
            end else begin
                w_acc_nx = w_rsh[W-1:0];
                w_lo_nx  = {r_lo[W-2:0], 1'b0};
            end
        end
    end

    // Signed ops run on magnitudes; signs are restored on the final edge.
    assign w_mag   = {w_acc_nx, w_lo_nx};
    assign w_prod  = r_neg_q ? -w_mag : w_mag;
    assign w_quo   = r_neg_q ? -w_lo_nx : w_lo_nx;
    assign w_rem   = r_neg_r ? -w_acc_nx : w_acc_nx;
    assign w_dbz   = r_is_div & (r_opnd == {W{1'b0}});
    assign w_final = !r_is_div ? w_prod :
                     w_dbz     ? {r_a, {W{1'b1}}} : {w_rem, w_quo};
    assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(W - 1));

    assign busy     = (r_state == S_RUN);
    assign cmd_end  = r_cmd_end;
    assign w_status = {r_bad_op, r_err_busy, r_ovf, r_dbz, r_cmd_end, busy};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NCH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        databus_out = '0;
        if (w_rd) begin
            case (addr)
                4'd3:    databus_out = r_res[int'(r_ptr_lo) * BW +: BW];
                4'd4:    databus_out = r_res[W + int'(r_ptr_hi) * BW +: BW];
                4'd5:    databus_out = {{(BW-6){1'b0}}, w_status};
                default: databus_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_res      <= '0;
            r_ptr_lo   <= '0;
            r_ptr_hi   <= '0;
            r_cmd_end  <= 1'b0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_err_busy <= 1'b0;
            r_bad_op   <= 1'b0;
        end else begin
            if (w_wr && addr == 4'd0 && r_state != S_RUN) r_a <= w_a_nxt;
            if (w_wr && addr == 4'd1 && r_state != S_RUN) r_b <= w_b_nxt;
            if (w_rd && addr == 4'd3) r_ptr_lo <= ptr_inc(r_ptr_lo);
            if (w_rd && addr == 4'd4) r_ptr_hi <= ptr_inc(r_ptr_hi);

            case (r_state)
                S_RUN: begin
                    if (w_cmd_wr) r_err_busy <= 1'b1;
                    r_acc <= w_acc_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_cmd_end <= 1'b1;
                        r_res     <= w_final;
                        r_dbz     <= w_dbz;
                        r_ovf     <= r_ovf_pend;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state    <= S_RUN;
                        r_cmd_end  <= 1'b0;
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_err_busy <= 1'b0;
                        r_bad_op   <= 1'b0;
                        r_ptr_lo   <= '0;
                        r_ptr_hi   <= '0;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_lo       <= w_a_abs;
                        r_opnd     <= w_b_abs;
                        r_is_div   <= databus_in[0];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_ovf_pend <= w_ovf_det;
                    end else begin
                        if (w_cmd_wr) r_bad_op <= 1'b1;
                        if (end_ack) begin
                            r_cmd_end <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imul_copro.sv
// Directed bench for imul_copro at W=32, BW=8: vector table plus hand sequences for busy/reset/ack corners.
module tb_imul_copro;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] databus_in = '0;
    logic [7:0] databus_out;
    logic [3:0] addr = '0;
    logic       cs = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       end_ack = 1'b0;
    logic       cmd_end;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    imul_copro #(.W(32), .BW(8)) dut (
        .clk        (clk),
        .arst       (arst),
        .databus_in (databus_in),
        .databus_out(databus_out),
        .addr       (addr),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .end_ack    (end_ack),
        .cmd_end    (cmd_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [7:0]  st;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; databus_in = d;
        @(posedge clk);
        #1 cs = 1'b0; wr = 1'b0; databus_in = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = databus_out;
        @(posedge clk);
        #1 cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_wr(a, w[8*i +: 8]);
    endtask

    task automatic rd_word(input logic [3:0] a, output logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            bus_rd(a, b);
            w[8*i +: 8] = b;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        end_ack = 1'b1;
        @(posedge clk);
        #1 end_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        int          n;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 8'h02};
        vecs[1] = '{2'b01, 32'd100,      32'd7,        32'd14,       32'd2,        8'h02};
        vecs[2] = '{2'b01, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678, 8'h06};
        vecs[3] = '{2'b00, 32'h12345678, 32'h10,       32'h23456780, 32'h00000001, 8'h02};
        vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'h0000000F, 8'h02};
        vecs[5] = '{2'b00, 32'h0,        32'd5,        32'h0,        32'h0,        8'h02};
        vecs[6] = '{2'b01, 32'd5,        32'd9,        32'd0,        32'd5,        8'h02};
        vecs[7] = '{2'b00, 32'h80000000, 32'd2,        32'h0,        32'h1,        8'h02};

        repeat (3) @(negedge clk);
        arst = 1'b1;
        check("rst busy", busy, 0);
        check("rst cmd_end", cmd_end, 0);
        bus_rd(4'd5, b);
        check("rst status", b, 8'h00);
        rd_word(4'd3, w);
        check("rst reslo", w, 0);

        for (int i = 0; i < 8; i++) begin
            wr_word(4'd0, vecs[i].a);
            wr_word(4'd1, vecs[i].b);
            bus_wr(4'd2, {6'd0, vecs[i].op});
            check($sformatf("v%0d busy start", i), busy, 1);
            count_busy(n);
            check($sformatf("v%0d busy len", i), n, 32);
            check($sformatf("v%0d cmd_end", i), cmd_end, 1);
            bus_rd(4'd5, b);
            check($sformatf("v%0d status", i), b, vecs[i].st);
            rd_word(4'd3, w);
            check($sformatf("v%0d reslo", i), w, vecs[i].lo);
            rd_word(4'd4, w);
            check($sformatf("v%0d reshi", i), w, vecs[i].hi);
            bus_rd(4'd3, b);
            check($sformatf("v%0d ptr wrap", i), b, vecs[i].lo[7:0]);
            pulse_ack();
            check($sformatf("v%0d ack clr", i), cmd_end, 0);
        end

        // Command and A write arriving mid-run must not disturb the multiply.
        wr_word(4'd0, 32'd3);
        wr_word(4'd1, 32'd5);
        bus_wr(4'd2, 8'h00);
        fork
            count_busy(n);
            begin
                repeat (4) @(negedge clk);
                bus_wr(4'd2, 8'h01);
                bus_wr(4'd0, 8'hAA);
            end
        join
        check("busy cmd len", n, 32);
        bus_rd(4'd5, b);
        check("err_busy status", b, 8'h12);
        rd_word(4'd3, w);
        check("err_busy reslo", w, 32'd15);
        rd_word(4'd4, w);
        check("err_busy reshi", w, 32'd0);

        // New command on the same edge as end_ack.
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 4'd2; databus_in = 8'h00; end_ack = 1'b1;
        @(posedge clk);
        #1 cs = 1'b0; wr = 1'b0; end_ack = 1'b0;
        check("ack+cmd cmd_end", cmd_end, 0);
        check("ack+cmd busy", busy, 1);
        count_busy(n);
        check("ack+cmd len", n, 32);
        rd_word(4'd3, w);
        check("ack+cmd A kept", w, 32'd15);
        bus_rd(4'd5, b);
        check("ack+cmd status", b, 8'h02);
        pulse_ack();

        // Reset in the middle of a multiply.
        wr_word(4'd0, 32'hFFFFFFFF);
        wr_word(4'd1, 32'd2);
        bus_wr(4'd2, 8'h00);
        repeat (10) @(negedge clk);
        arst = 1'b0;
        #1;
        check("mid rst busy", busy, 0);
        check("mid rst cmd_end", cmd_end, 0);
        cs = 1'b1; rd = 1'b1; addr = 4'd5;
        #1 check("mid rst status", databus_out, 8'h00);
        addr = 4'd3;
        #1 check("mid rst reslo", databus_out, 8'h00);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        cs = 1'b1; wr = 1'b1; addr = 4'd0; databus_in = 8'h04;
        @(posedge clk);
        #1 cs = 1'b0; wr = 1'b0; databus_in = '0;
        bus_wr(4'd0, 8'h00);
        bus_wr(4'd0, 8'h00);
        bus_wr(4'd0, 8'h00);
        wr_word(4'd1, 32'd6);
        bus_wr(4'd2, 8'h00);
        count_busy(n);
        check("post rst len", n, 32);
        rd_word(4'd3, w);
        check("post rst first write", w, 32'd24);
        pulse_ack();

        wr_word(4'd0, 32'hFFFFFFF9);
        wr_word(4'd1, 32'd2);
        bus_wr(4'd2, 8'h03);
`ifdef IMUL_SIGNED_EN
        count_busy(n);
        check("sdiv len", n, 32);
        rd_word(4'd3, w);
        check("sdiv reslo", w, 32'hFFFFFFFD);
        rd_word(4'd4, w);
        check("sdiv reshi", w, 32'hFFFFFFFF);
        pulse_ack();
        wr_word(4'd0, 32'h80000000);
        wr_word(4'd1, 32'hFFFFFFFF);
        bus_wr(4'd2, 8'h03);
        count_busy(n);
        check("ovf len", n, 32);
        bus_rd(4'd5, b);
        check("ovf status", b, 8'h0A);
        rd_word(4'd3, w);
        check("ovf reslo", w, 32'h80000000);
        rd_word(4'd4, w);
        check("ovf reshi", w, 32'h0);
        pulse_ack();
`else
        check("badop busy", busy, 0);
        @(negedge clk);
        check("badop busy later", busy, 0);
        check("badop cmd_end", cmd_end, 0);
        bus_rd(4'd5, b);
        check("badop status", b, 8'h20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
